// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor.
//
// One operand bit is processed per clock, LSB first, through a single full
// adder and a 1-bit carry register. An operation accepted in IDLE spends
// WIDTH cycles in BUSY and then pulses done for one cycle in DONE.
//
// Optional feature: define SERIAL_ADDSUB_SATURATE_EN to clamp the result to
// the most positive / most negative value on signed overflow.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - operation request, sampled only in IDLE
//   control   - 4'b1000 add, 4'b1001 subtract (num1 - num2), others rejected
//   num1/num2 - two's-complement operands, sampled with start
//   busy      - high while bits are being processed
//   done      - one-cycle pulse, result and flags valid
//   err       - one-cycle pulse on start with an unsupported control code
//   result    - sum or difference, held until the next done
//   carry, overflow, zero, negative - C/V/Z/N flags of the last operation

module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              c_q, c_d;
    logic              sub_q, sub_d;
    logic              msb1_q, msb1_d;
    logic              msb2_q, msb2_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
    logic              negative_q, negative_d;

    logic              supported;
    logic              bb;
    logic              s_bit;
    logic              c_out;
    logic [WIDTH-1:0]  res_raw;
    logic [WIDTH-1:0]  res_fin;
    logic              ovf;

    assign supported = (control[3:1] == 3'b100);

    // Full adder on the current LSBs; subtraction inverts b and seeds carry=1.
    assign bb    = b_q[0] ^ sub_q;
    assign s_bit = a_q[0] ^ bb ^ c_q;
    assign c_out = (a_q[0] & bb) | (c_q & (a_q[0] ^ bb));

    // Value of the sum register once the final (MSB) bit has been shifted in.
    assign res_raw = {s_bit, sum_q[WIDTH-1:1]};
    assign ovf     = (msb1_q ^ s_bit) & ~(msb1_q ^ msb2_q ^ sub_q);

`ifdef SERIAL_ADDSUB_SATURATE_EN
    always_comb begin
        res_fin = res_raw;
        if (ovf) begin
            res_fin = msb1_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_fin = res_raw;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        c_d        = c_q;
        sub_d      = sub_q;
        msb1_d     = msb1_q;
        msb2_d     = msb2_q;
        err_d      = 1'b0;
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (supported) begin
                        a_d     = num1;
                        b_d     = num2;
                        sum_d   = '0;
                        cnt_d   = '0;
                        sub_d   = control[0];
                        c_d     = control[0];
                        msb1_d  = num1[WIDTH-1];
                        msb2_d  = num2[WIDTH-1];
                        state_d = StBusy;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = res_raw;
                c_d   = c_out;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d    = StDone;
                    result_d   = res_fin;
                    carry_d    = c_out;
                    overflow_d = ovf;
                    zero_d     = (res_fin == '0);
                    negative_d = res_fin[WIDTH-1];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            c_q        <= 1'b0;
            sub_q      <= 1'b0;
            msb1_q     <= 1'b0;
            msb2_q     <= 1'b0;
            err_q      <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            sub_q      <= sub_d;
            msb1_q     <= msb1_d;
            msb2_q     <= msb2_d;
            err_q      <= err_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign busy     = (state_q == StBusy);
    assign done     = (state_q == StDone);
    assign err      = err_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign negative = negative_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub (WIDTH=8): directed operations with a queue of
// expected results produced by an arithmetic reference model.

module tb_serial_addsub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] control;
    logic [7:0] num1;
    logic [7:0] num2;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } exp_t;

    exp_t sb_q[$];

    serial_addsub #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .control (control),
        .num1    (num1),
        .num2    (num2),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result),
        .carry   (carry),
        .overflow(overflow),
        .zero    (zero),
        .negative(negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, independent of the serial datapath.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        logic [8:0] full;
        int         sa;
        int         sbv;
        int         r;
        exp_t       e;
        sa  = $signed(a);
        sbv = $signed(b);
        full = sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
        r    = sub ? (sa - sbv) : (sa + sbv);
        e.v   = (r > 127) || (r < -128);
        e.res = full[7:0];
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (e.v) e.res = (sa < 0) ? 8'h80 : 8'h7F;
`endif
        e.c = full[8];
        e.z = (e.res == 8'h00);
        e.n = e.res[7];
        return e;
    endfunction

    // Runs one operation; with poke set, a second start with other operands is
    // driven during BUSY and must be ignored.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] ctl,
                         input string tag, input bit poke);
        int         edges;
        bit         seen;
        logic [7:0] prev_res;
        exp_t       e;
        sb_q.push_back(model(a, b, ctl[0]));
        prev_res = result;
        @(negedge clk);
        start = 1'b1; control = ctl; num1 = a; num2 = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0; num1 = ~a; num2 = ~b; control = 4'b0000;
        check({tag, " busy"}, busy, 1);
        seen = 0;
        while (!seen && edges < 40) begin
            if (poke && edges == 3) begin
                start = 1'b1; control = 4'b1001; num1 = 8'h11; num2 = 8'h22;
            end
            if (poke && edges == 4) begin
                start = 1'b0;
                check({tag, " err in busy"}, err, 0);
            end
            if (edges == 5) check({tag, " result held"}, result, prev_res);
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
        end
        check({tag, " latency"}, seen ? edges : 0, 9);
        e = sb_q.pop_front();
        if (seen) begin
            check({tag, " result"}, result, e.res);
            check({tag, " flags"}, {carry, overflow, zero, negative}, {e.c, e.v, e.z, e.n});
            check({tag, " busy at done"}, busy, 0);
            @(negedge clk);
            check({tag, " done pulse"}, done, 0);
            check({tag, " result hold"}, result, e.res);
        end
    endtask

    initial begin
        int         done_cnt;
        logic [7:0] keep;
        rst_n = 1'b0; start = 1'b0; control = 4'b0000; num1 = '0; num2 = '0;
        repeat (2) @(negedge clk);
        check("reset outs", {busy, done, err, carry, overflow, zero, negative}, 0);
        check("reset result", result, 0);
        rst_n = 1'b1;

        do_op(8'h05, 8'h03, 4'b1000, "add 5+3", 0);
        do_op(8'h7F, 8'h01, 4'b1000, "add 7f+1", 0);
        do_op(8'h05, 8'h05, 4'b1001, "sub 5-5", 0);
        do_op(8'h80, 8'h01, 4'b1001, "sub 80-1", 0);
        do_op(8'hFF, 8'h01, 4'b1000, "add ff+1", 0);
        do_op(8'h03, 8'h05, 4'b1001, "sub 3-5", 0);

        // Unsupported code: one-cycle err, no operation, outputs untouched.
        keep = result;
        @(negedge clk);
        start = 1'b1; control = 4'b0010; num1 = 8'h44; num2 = 8'h55;
        @(negedge clk);
        start = 1'b0;
        check("bad code err", err, 1);
        check("bad code busy", busy, 0);
        check("bad code result", result, keep);
        @(negedge clk);
        check("bad code err pulse", err, 0);
        check("bad code busy2", busy, 0);
        check("bad code result2", result, keep);

        do_op(8'h21, 8'h13, 4'b1000, "poke busy", 1);

        // Reset during the fourth BUSY cycle aborts with no done.
        @(negedge clk);
        start = 1'b1; control = 4'b1000; num1 = 8'h12; num2 = 8'h34;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid reset outs", {busy, done, err, carry, overflow, zero, negative}, 0);
        check("mid reset result", result, 0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("no done after abort", done_cnt, 0);
        rst_n = 1'b1;
        do_op(8'h12, 8'h34, 4'b1000, "after reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
